fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and hazard controller for the ID stage.
- Generalises register-operand bypass to NUM_RS source ports, with three bypass sources: EX, MEM and WB.
- Adds load-use stall generation, wait handling for a multi-cycle data memory, a stall-cycle counter and a MEM-wait watchdog.
- Sits beside the ID/EX pipeline registers and drives the ID operand muxes and the IF/ID hold / EX bubble controls.

Parameters:
- XLEN, 32, data width.
- NUM_RS, 2, number of ID source-operand ports (1..4).
- REG_AW, 5, register address width.
- CNT_W, 16, width of the stall-cycle counter.
- TIMEOUT, 255, number of consecutive MEM_WAIT cycles before the watchdog flag is set.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- rs_addr_id  in  NUM_RS*REG_AW  packed source addresses; port i occupies bits [i*REG_AW +: REG_AW].
- rs_used_id  in  NUM_RS  per-port "operand actually read" mask.
- rd_addr_ex  in  REG_AW  EX destination register.
- reg_write_en_ex  in  1  EX writes a register.
- is_load_ex  in  1  EX instruction is a load.
- cal_result_ex  in  XLEN  EX ALU result.
- rd_addr_mem  in  REG_AW  MEM destination register.
- reg_write_en_mem  in  1  MEM writes a register.
- is_load_mem  in  1  MEM instruction is a load.
- mem_data_valid  in  1  load data is valid this cycle.
- wb_data_mem  in  XLEN  MEM writeback value (load data or passed ALU result).
- rd_addr_wb  in  REG_AW  WB destination register.
- reg_write_en_wb  in  1  WB writes a register.
- wb_data_wb  in  XLEN  WB value.
- rs_data_id  out  NUM_RS*XLEN  packed forwarded data.
- rs_forward_en  out  NUM_RS  per-port forward select.
- stall_id  out  1  hold PC and IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX.
- hz_state  out  2  FSM state (debug).
- stall_cycles  out  CNT_W  saturating stall-cycle count.
- hazard_timeout  out  1  sticky watchdog flag.

Behaviour:
- Per-port matching, port i:
  - mX_i = rs_used_id[i] && addr_i != 0 && reg_write_en_X && rd_addr_X == addr_i, for X in ex/mem/wb.
  - An rd of 0 never matches.
- Source priority: EX > MEM > WB (youngest wins).
  - EX match with is_load_ex=0 → data = cal_result_ex.
  - Else MEM match → data = wb_data_mem.
  - Else WB match → data = wb_data_wb.
  - rs_forward_en[i] = 1 whenever any of these sources is selected.
  - No match → rs_data_id port = 0, rs_forward_en[i] = 0.
- Per-port hazard, hz_i, is set if either holds:
  - mEX_i && is_load_ex.
  - mEX_i false && mMEM_i && is_load_mem && !mem_data_valid.
  - While hz_i is set, rs_forward_en[i] = 0.
- Stall outputs: hazard = OR of all hz_i. stall_id = bubble_ex = hazard, combinational, same cycle.
- Forwarding, hazard and stall outputs are purely combinational; reset does not gate them.
- FSM states: RUN=0, LU_STALL=1, MEM_WAIT=2. Reset → RUN.
  - RUN: hazard from an EX load → LU_STALL; hazard from a MEM load → MEM_WAIT; otherwise stay.
  - LU_STALL: no hazard → RUN; hazard from a MEM load → MEM_WAIT; an EX-load hazard (new producer) → stay.
  - MEM_WAIT: no hazard → RUN; hazard from an EX load → LU_STALL; otherwise stay.
  - When both causes are present, the EX cause takes precedence.
- stall_cycles:
  - Reset value 0.
  - +1 on every clk with hazard=1.
  - Saturates at 2^CNT_W-1; no wrap.
- Watchdog:
  - An internal counter, reset to 0, increments each cycle the FSM is in MEM_WAIT and hazard=1.
  - It clears on any other cycle.
  - When the counter reaches TIMEOUT, hazard_timeout is set on the next edge and stays 1 until reset.
  - hazard_timeout does not alter stall behaviour.
- Reset mid-stall: the next edge with rst_n=0 forces state RUN, counters 0 and the flag 0, regardless of inputs.
- Ports are independent: any single hazarding port stalls; non-hazard ports still forward.

Test Plan:
- Priority: rs1=5; EX rd=5 ALU result 0x11; MEM rd=5 data 0x22; WB rd=5 data 0x33 → rs_data port0=0x11, fwd_en[0]=1, stall=0. Drop the EX match → 0x22. Drop the MEM match → 0x33.
- x0 and unused ports:
  - rs1=0 with EX rd=0 write → fwd_en[0]=0, data 0.
  - rs2=7, rs_used[1]=0, EX load rd=7 → no stall.
- Load-use: EX load rd=3, rs2=3 used → stall_id=bubble_ex=1, fwd_en[1]=0; next cycle hz_state=1, stall_cycles=1. Then the load moves to MEM with mem_data_valid=1 → forward wb_data_mem, stall=0, state returns to 0.
- Multi-cycle memory: MEM load rd=9, valid=0 for 4 cycles, rs1=9 → stall for 4 cycles, hz_state=2, stall_cycles=4. Assert valid → data forwarded, RUN.
- Watchdog and saturation:
  - TIMEOUT=3, valid held 0 for 10 cycles → hazard_timeout=1 and remains 1 after the hazard clears.
  - With CNT_W=4, 20 stall cycles → stall_cycles=15.
- Reset mid-MEM_WAIT: rst_n=0 for one edge → hz_state=0, stall_cycles=0, hazard_timeout=0; stall_id still follows the inputs combinationally.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// ID-stage operand forwarding (EX > MEM > WB) with load-use / slow-memory stall
// control, a saturating stall-cycle counter and a sticky MEM-wait watchdog.
module fwd_hazard_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_RS  = 2,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RS*REG_AW-1:0] rs_addr_id,
    input  logic [NUM_RS-1:0]        rs_used_id,
    input  logic [REG_AW-1:0]        rd_addr_ex,
    input  logic                     reg_write_en_ex,
    input  logic                     is_load_ex,
    input  logic [XLEN-1:0]          cal_result_ex,
    input  logic [REG_AW-1:0]        rd_addr_mem,
    input  logic                     reg_write_en_mem,
    input  logic                     is_load_mem,
    input  logic                     mem_data_valid,
    input  logic [XLEN-1:0]          wb_data_mem,
    input  logic [REG_AW-1:0]        rd_addr_wb,
    input  logic                     reg_write_en_wb,
    input  logic [XLEN-1:0]          wb_data_wb,
    output logic [NUM_RS*XLEN-1:0]   rs_data_id,
    output logic [NUM_RS-1:0]        rs_forward_en,
    output logic                     stall_id,
    output logic                     bubble_ex,
    output logic [1:0]               hz_state,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic                     hazard_timeout
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    logic [NUM_RS-1:0] hz_ex_v;
    logic [NUM_RS-1:0] hz_mem_v;
    logic              hazard;
    logic              hz_from_ex;
    logic              hz_from_mem;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              flag_q, flag_d;

    for (genvar g = 0; g < NUM_RS; g++) begin : g_port
        logic [REG_AW-1:0] addr;
        logic              m_ex;
        logic              m_mem;
        logic              m_wb;
        logic              hz;

        assign addr  = rs_addr_id[g*REG_AW +: REG_AW];
        assign m_ex  = rs_used_id[g] && (addr != '0) && reg_write_en_ex  && (rd_addr_ex  == addr);
        assign m_mem = rs_used_id[g] && (addr != '0) && reg_write_en_mem && (rd_addr_mem == addr);
        assign m_wb  = rs_used_id[g] && (addr != '0) && reg_write_en_wb  && (rd_addr_wb  == addr);

        assign hz_ex_v[g]  = m_ex && is_load_ex;
        assign hz_mem_v[g] = !m_ex && m_mem && is_load_mem && !mem_data_valid;
        assign hz          = hz_ex_v[g] || hz_mem_v[g];

        // A hazarding port forwards nothing; an older source must not leak through.
        assign rs_forward_en[g] = !hz && (m_ex || m_mem || m_wb);
        assign rs_data_id[g*XLEN +: XLEN] = hz    ? '0            :
                                            m_ex  ? cal_result_ex :
                                            m_mem ? wb_data_mem   :
                                            m_wb  ? wb_data_wb    : '0;
    end

    assign hz_from_ex  = |hz_ex_v;
    assign hz_from_mem = |hz_mem_v;
    assign hazard      = hz_from_ex || hz_from_mem;
    assign stall_id    = hazard;
    assign bubble_ex   = hazard;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (hz_from_ex)       state_d = ST_LU_STALL;
                else if (hz_from_mem) state_d = ST_MEM_WAIT;
            end
            ST_LU_STALL: begin
                if (!hazard)          state_d = ST_RUN;
                else if (hz_from_ex)  state_d = ST_LU_STALL;
                else                  state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (!hazard)          state_d = ST_RUN;
                else if (hz_from_ex)  state_d = ST_LU_STALL;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (hazard && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end

        // Watchdog holds at the limit so it can never wrap back below it.
        wd_d = '0;
        if ((state_q == ST_MEM_WAIT) && hazard) begin
            wd_d = (wd_q == WD_LIMIT) ? wd_q : wd_q + 1'b1;
        end

        flag_d = flag_q || (wd_q == WD_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            stall_q <= '0;
            wd_q    <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            wd_q    <= wd_d;
            flag_q  <= flag_d;
        end
    end

    assign hz_state       = state_q;
    assign stall_cycles   = stall_q;
    assign hazard_timeout = flag_q;

endmodule
